// File: rtl/hazard_detect_unit_if.sv
// hazard_detect_unit_if: decode-stage hazard bus; master drives decode info, slave returns stall/flush status.
interface hazard_detect_unit_if #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic             id_readEn1;
    logic             id_readEn2;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_regWrite;
    logic [REG_W-1:0] id_writeReg;
    logic             id_memRead;
    logic             id_branch;
    logic             id_jump;
    logic             ex_redirect;
    logic             stall;
    logic             flush;
    logic             ctrl_pending;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_readEn1, id_readEn2, id_rs, id_rt, id_regWrite,
               id_writeReg, id_memRead, id_branch, id_jump, ex_redirect,
        input  stall, flush, ctrl_pending, stall_count
    );

    modport slave (
        input  id_valid, id_readEn1, id_readEn2, id_rs, id_rt, id_regWrite,
               id_writeReg, id_memRead, id_branch, id_jump, ex_redirect,
        output stall, flush, ctrl_pending, stall_count
    );
endinterface

// File: rtl/hazard_detect_unit.sv
// hazard_detect_unit: decode-stage RAW hazard detector with EX/MEM/WB scoreboard, stall/flush and stall counter.
// Define HAZARD_FORWARDING_EN to stall only on load-use hazards against the EX entry.
module hazard_detect_unit #(
    parameter int REG_W = 3,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_detect_unit_if.slave  bus
);
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             is_load;
    } entry_t;

    entry_t ex_e, mem_e, wb_e, ex_next;
    logic   match_ex, match_mem, raw, stall_i, flush_i, set_pending;
    logic   unused_sb;

    always_comb begin
        match_ex  = ex_e.valid && ((bus.id_readEn1 && bus.id_rs == ex_e.rd) ||
                                   (bus.id_readEn2 && bus.id_rt == ex_e.rd));
        match_mem = mem_e.valid && ((bus.id_readEn1 && bus.id_rs == mem_e.rd) ||
                                    (bus.id_readEn2 && bus.id_rt == mem_e.rd));
`ifdef HAZARD_FORWARDING_EN
        raw = bus.id_valid && match_ex && ex_e.is_load;
`else
        raw = bus.id_valid && (match_ex || match_mem);
`endif
        // A redirect makes the decode instruction wrong-path, so it beats the stall.
        stall_i     = rst_n && raw && !bus.ex_redirect;
        flush_i     = rst_n && bus.ex_redirect;
        set_pending = bus.id_valid && (bus.id_branch || bus.id_jump) && !stall_i && !flush_i;
        ex_next     = (stall_i || flush_i || !bus.id_valid || !bus.id_regWrite) ? '0 :
                      {1'b1, bus.id_writeReg, bus.id_memRead};
    end

    assign bus.stall = stall_i;
    assign bus.flush = flush_i;

    // WB is tracked for pipeline fidelity but never hazards thanks to the register-file bypass.
    assign unused_sb = ^{wb_e, match_mem};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_e             <= '0;
            mem_e            <= '0;
            wb_e             <= '0;
            bus.ctrl_pending <= 1'b0;
            bus.stall_count  <= '0;
        end else begin
            wb_e             <= mem_e;
            mem_e            <= ex_e;
            ex_e             <= ex_next;
            bus.ctrl_pending <= set_pending;
            if (stall_i && bus.stall_count != '1)
                bus.stall_count <= bus.stall_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_detect_unit.sv
// tb_hazard_detect_unit: directed checks of stall/flush/ctrl_pending/stall_count for both build flavours.
module tb_hazard_detect_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    int   exp_cnt = 0;

`ifdef HAZARD_FORWARDING_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    hazard_detect_unit_if #(.REG_W(3), .CNT_W(16)) bus ();
    hazard_detect_unit #(.REG_W(3), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic r1, input logic r2, input logic [2:0] rs,
                         input logic [2:0] rt, input logic rw, input logic [2:0] wr,
                         input logic mr, input logic br, input logic jp, input logic rd);
        bus.id_valid    = v;
        bus.id_readEn1  = r1;
        bus.id_readEn2  = r2;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_regWrite = rw;
        bus.id_writeReg = wr;
        bus.id_memRead  = mr;
        bus.id_branch   = br;
        bus.id_jump     = jp;
        bus.ex_redirect = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        drive(0, 0, 0, 3'd0, 3'd0, 0, 3'd0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        nop();
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1, 1, 0, 3'd1, 3'd0, 1, 3'd1, 0, 0, 0, 1);
        total++; if (bus.flush !== 1'b0) $display("FAIL reset_flush: got %b want 0", bus.flush); else passed++;
        total++; if (bus.stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.stall); else passed++;
        tick();
        total++; if (bus.ctrl_pending !== 1'b0) $display("FAIL reset_pending: got %b want 0", bus.ctrl_pending); else passed++;
        total++; if (bus.stall_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", bus.stall_count); else passed++;
        rst_n = 1'b1;
        exp_cnt = 0;
        idle(3);
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 0, 3'd2, 3'd0, 1, 3'd1, 0, 0, 0, 0);
        total++; if (bus.stall !== 1'b0) $display("FAIL b2b_writer: stall=%b want 0", bus.stall); else passed++;
        tick();
        drive(1, 1, 1, 3'd1, 3'd3, 1, 3'd2, 0, 0, 0, 0);
        total++; if (bus.stall !== !FWD) $display("FAIL b2b_stall_c1: stall=%b want %b", bus.stall, !FWD); else passed++;
        tick();
        total++; if (bus.stall !== !FWD) $display("FAIL b2b_stall_c2: stall=%b want %b", bus.stall, !FWD); else passed++;
        tick();
        total++; if (bus.stall !== 1'b0) $display("FAIL b2b_stall_c3: stall=%b want 0", bus.stall); else passed++;
        exp_cnt += FWD ? 0 : 2;
        nop();
        tick();
        total++; if (bus.stall_count !== 16'(exp_cnt)) $display("FAIL b2b_count: got %0d want %0d", bus.stall_count, exp_cnt); else passed++;
        idle(3);
    endtask

    task automatic test_load_use();
        drive(1, 0, 0, 3'd0, 3'd0, 1, 3'd4, 1, 0, 0, 0);
        tick();
        drive(1, 1, 0, 3'd4, 3'd0, 1, 3'd5, 0, 0, 0, 0);
        total++; if (bus.stall !== 1'b1) $display("FAIL lu_stall_c1: stall=%b want 1", bus.stall); else passed++;
        tick();
        total++; if (bus.stall !== !FWD) $display("FAIL lu_stall_c2: stall=%b want %b", bus.stall, !FWD); else passed++;
        tick();
        total++; if (bus.stall !== 1'b0) $display("FAIL lu_stall_c3: stall=%b want 0", bus.stall); else passed++;
        exp_cnt += FWD ? 1 : 2;
        nop();
        tick();
        total++; if (bus.stall_count !== 16'(exp_cnt)) $display("FAIL lu_count: got %0d want %0d", bus.stall_count, exp_cnt); else passed++;
        idle(3);
    endtask

    task automatic test_distance();
        drive(1, 0, 0, 3'd0, 3'd0, 1, 3'd6, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 3'd1, 3'd0, 1, 3'd7, 0, 0, 0, 0);
        tick();
        drive(1, 1, 1, 3'd0, 3'd6, 0, 3'd0, 0, 0, 0, 0);
        total++; if (bus.stall !== !FWD) $display("FAIL dist2_rt: stall=%b want %b", bus.stall, !FWD); else passed++;
        tick();
        total++; if (bus.stall !== 1'b0) $display("FAIL dist2_release: stall=%b want 0", bus.stall); else passed++;
        exp_cnt += FWD ? 0 : 1;
        idle(3);
        drive(1, 0, 0, 3'd0, 3'd0, 1, 3'd6, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 3'd1, 3'd0, 1, 3'd7, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 3'd0, 3'd6, 0, 3'd0, 0, 0, 0, 0);
        total++; if (bus.stall !== 1'b0) $display("FAIL dist2_rt_disabled: stall=%b want 0", bus.stall); else passed++;
        idle(3);
        drive(1, 0, 0, 3'd0, 3'd0, 1, 3'd6, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 3'd1, 3'd0, 1, 3'd7, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 3'd2, 3'd0, 1, 3'd3, 0, 0, 0, 0);
        tick();
        drive(1, 0, 1, 3'd0, 3'd6, 0, 3'd0, 0, 0, 0, 0);
        total++; if (bus.stall !== 1'b0) $display("FAIL dist3_rt: stall=%b want 0", bus.stall); else passed++;
        nop();
        tick();
        total++; if (bus.stall_count !== 16'(exp_cnt)) $display("FAIL dist_count: got %0d want %0d", bus.stall_count, exp_cnt); else passed++;
        idle(3);
    endtask

    task automatic test_redirect();
        drive(1, 0, 0, 3'd0, 3'd0, 1, 3'd2, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 3'd2, 3'd0, 1, 3'd3, 1, 0, 0, 1);
        total++; if (bus.stall !== 1'b0) $display("FAIL redir_stall: stall=%b want 0", bus.stall); else passed++;
        total++; if (bus.flush !== 1'b1) $display("FAIL redir_flush: flush=%b want 1", bus.flush); else passed++;
        tick();
        drive(1, 1, 0, 3'd3, 3'd0, 0, 3'd0, 0, 0, 0, 0);
        total++; if (bus.stall !== 1'b0) $display("FAIL redir_ex_bubble: stall=%b want 0", bus.stall); else passed++;
        total++; if (bus.flush !== 1'b0) $display("FAIL redir_flush_drop: flush=%b want 0", bus.flush); else passed++;
        total++; if (bus.stall_count !== 16'(exp_cnt)) $display("FAIL redir_count: got %0d want %0d", bus.stall_count, exp_cnt); else passed++;
        idle(3);
    endtask

    task automatic test_ctrl_pending();
        drive(1, 1, 0, 3'd5, 3'd0, 0, 3'd0, 0, 1, 0, 0);
        total++; if (bus.ctrl_pending !== 1'b0) $display("FAIL ctrl_before: pending=%b want 0", bus.ctrl_pending); else passed++;
        tick();
        total++; if (bus.ctrl_pending !== 1'b1) $display("FAIL ctrl_set: pending=%b want 1", bus.ctrl_pending); else passed++;
        nop();
        tick();
        total++; if (bus.ctrl_pending !== 1'b0) $display("FAIL ctrl_clear: pending=%b want 0", bus.ctrl_pending); else passed++;
        drive(1, 1, 0, 3'd5, 3'd0, 0, 3'd0, 0, 1, 0, 0);
        tick();
        drive(1, 0, 0, 3'd0, 3'd0, 1, 3'd7, 0, 0, 1, 0);
        tick();
        total++; if (bus.ctrl_pending !== 1'b1) $display("FAIL ctrl_set_wins: pending=%b want 1", bus.ctrl_pending); else passed++;
        nop();
        tick();
        total++; if (bus.ctrl_pending !== 1'b0) $display("FAIL ctrl_clear2: pending=%b want 0", bus.ctrl_pending); else passed++;
        idle(3);
        drive(1, 0, 0, 3'd0, 3'd0, 1, 3'd1, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 3'd1, 3'd0, 0, 3'd0, 0, 1, 0, 0);
        total++; if (bus.stall !== !FWD) $display("FAIL ctrl_stalled_branch: stall=%b want %b", bus.stall, !FWD); else passed++;
        tick();
        exp_cnt += FWD ? 0 : 1;
        total++; if (bus.ctrl_pending !== FWD) $display("FAIL ctrl_stall_blocks: pending=%b want %b", bus.ctrl_pending, FWD); else passed++;
        idle(3);
        total++; if (bus.stall_count !== 16'(exp_cnt)) $display("FAIL ctrl_count: got %0d want %0d", bus.stall_count, exp_cnt); else passed++;
    endtask

    task automatic test_reset_mid_stall();
        drive(1, 0, 0, 3'd0, 3'd0, 1, 3'd1, 1, 0, 0, 0);
        tick();
        drive(1, 1, 0, 3'd1, 3'd0, 0, 3'd0, 0, 0, 0, 0);
        total++; if (bus.stall !== 1'b1) $display("FAIL rst_mid_pre: stall=%b want 1", bus.stall); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (bus.stall !== 1'b0) $display("FAIL rst_mid_drop: stall=%b want 0", bus.stall); else passed++;
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        #1;
        total++; if (bus.stall !== 1'b0) $display("FAIL rst_mid_after: stall=%b want 0", bus.stall); else passed++;
        total++; if (bus.stall_count !== 16'd0) $display("FAIL rst_mid_count: got %0d want 0", bus.stall_count); else passed++;
        tick();
        total++; if (bus.stall !== 1'b0) $display("FAIL rst_mid_after2: stall=%b want 0", bus.stall); else passed++;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_distance();
        test_redirect();
        test_ctrl_pending();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/hazard_detect_unit.md
# hazard_detect_unit

Decode-stage hazard detector and stall generator for the five-stage pipeline. It consumes the per-instruction register-read enables, branch and jump flags produced by opcode decode. It tracks in-flight register writers in a three-entry scoreboard mirroring the EX/MEM/WB stages, and asserts stall (hold PC and IF/ID, inject bubble into ID/EX) or flush (squash IF/ID on redirect). It also keeps a saturating count of stall cycles for performance debug.

## Interface
Parameters:
- REG_W, 3, register-number width (8 architectural registers)
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_readEn1  in  1  instruction reads Rs
- id_readEn2  in  1  instruction reads Rt
- id_rs  in  REG_W  source register 1
- id_rt  in  REG_W  source register 2
- id_regWrite  in  1  instruction writes a register
- id_writeReg  in  REG_W  destination register
- id_memRead  in  1  instruction is a load (LD)
- id_branch  in  1  conditional branch in decode
- id_jump  in  1  J/JR/JAL/JALR in decode
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle
- stall  out  1  hold PC and IF/ID; ID/EX receives NOP
- flush  out  1  squash IF/ID contents
- ctrl_pending  out  1  a branch/jump is between ID and EX resolution
- stall_count  out  CNT_W  stall cycles since reset, saturating

## Operation
- Scoreboard entries EX, MEM, WB, each {valid, reg[REG_W-1:0], isLoad}.
- Match on entry e: e.valid and ((id_readEn1 and id_rs==e.reg) or (id_readEn2 and id_rt==e.reg)). Register 0 gets no special treatment.
- Raw hazard: id_valid and (match on EX or match on MEM). WB is never a hazard because the register file bypasses same-cycle writes.
- stall = raw hazard and not ex_redirect.
- flush = ex_redirect. Redirect overrides stall because the decode instruction is wrong-path.
- Scoreboard shift every cycle: WB<=MEM, MEM<=EX.
- EX update:
  - EX<=invalid when stall, flush or !id_valid.
  - Otherwise EX<={id_regWrite, id_writeReg, id_memRead}. valid=0 when id_regWrite=0.
- ctrl_pending:
  - Sets when id_valid and (id_branch or id_jump) and not stall and not flush.
  - Clears the next cycle, when the instruction is in EX and resolves.
  - If set and clear coincide, the set wins.
- stall_count increments on each cycle with stall=1 and holds at all-ones.

## Timing
- Reset (rst_n=0 at edge): all entries invalid, ctrl_pending=0, stall_count=0. stall and flush are forced 0 while rst_n=0.
- stall and flush are combinational from registered scoreboard plus current-cycle inputs, with zero latency.
- Non-forwarding build: a dependent immediately behind its writer stalls 2 cycles; at distance 2 it stalls 1 cycle; at distance 3 or more it does not stall.
- Stall persists while the hazard persists. The bubble shifts the writer forward, so a stall self-clears without external action.
- Reset mid-stall drops stall the same cycle and loses all scoreboard state.
- ex_redirect coinciding with a hazard: stall=0, flush=1, EX gets a bubble, stall_count does not increment.

## Configuration
- HAZARD_FORWARDING_EN defined:
  - EX/MEM forwarding is assumed to exist.
  - Raw hazard = match on EX entry with isLoad=1 only (load-use, exactly 1 stall cycle).
  - MEM matches and non-load EX matches never stall.
- Undefined: full interlock as described in Operation.

## Test plan
- Back-to-back ADD r1 then ADD r2,r1,r3 (readEn1=1, rs=1): stall=1 for 2 cycles, then 0. In the forwarding build, stall never asserts. stall_count=2 or 0 respectively.
- LD r4 then ADDI r5,r4 (readEn1=1): stall=1 for 2 cycles without forwarding, 1 cycle with forwarding.
- ST using rt=r6 (readEn2=1) after writer of r6 with one independent instruction between: 1 stall cycle without forwarding. With readEn2=0 and the same rt, no stall.
- Writer r2 followed by dependent, with ex_redirect=1 on the first would-be stall cycle: stall=0, flush=1, EX entry invalid, stall_count unchanged.
- BEQZ accepted (id_branch=1): ctrl_pending=1 exactly one cycle. A JAL accepted in that same clear cycle keeps ctrl_pending=1.
- Drive rst_n=0 during an active stall: stall=0 that cycle. After release, a dependent of the pre-reset writer does not stall, and stall_count=0.
